// File: rtl/toycpu_pkg.sv
// Shared toycpu decode definitions: opcodes, next-PC encodings and the fixed-width
// control-strobe bundle carried by the decode output register.
package toycpu_pkg;

    localparam logic [2:0] OP_ALU = 3'b000;
    localparam logic [2:0] OP_LDI = 3'b001;
    localparam logic [2:0] OP_LDR = 3'b011;
    localparam logic [2:0] OP_ST  = 3'b101;
    localparam logic [2:0] OP_BR  = 3'b110;

    localparam logic [1:0] PC_INC = 2'b00;
    localparam logic [1:0] PC_BR  = 2'b01;

    // Width-independent strobes; parametrised fields travel beside this struct.
    typedef struct packed {
        logic [1:0] nextPCSel;
        logic       regDataInSource;
        logic       immData;
        logic       regFileWE;
        logic       memWE;
        logic       dAddrSel;
        logic       illegal;
    } ctrl_t;

endpackage

// File: rtl/decode_stage_if.sv
// Fetch-side, execute-side and writeback signals of the decode stage.
// The decode stage uses the slave modport; its environment drives through master.
interface decode_stage_if #(
    parameter int DATA_W  = 16,
    parameter int REG_CNT = 4,
    parameter int ALUOP_W = 7
);
    localparam int REG_W = $clog2(REG_CNT);

    logic               inValid;
    logic               inReady;
    logic [DATA_W-1:0]  instruction;
    logic               cFlag;
    logic               zFlag;
    logic               flush;
    logic               outValid;
    logic               outReady;
    logic [1:0]         nextPCSel;
    logic               regDataInSource;
    logic               immData;
    logic               regFileWE;
    logic               memWE;
    logic               dAddrSel;
    logic [REG_W-1:0]   regDst;
    logic [REG_W-1:0]   regSrc1;
    logic [REG_W-1:0]   regSrc2;
    logic [ALUOP_W-1:0] aluOp;
    logic [DATA_W-1:0]  instrData;
    logic               illegal;
    logic               wbValid;
    logic [REG_W-1:0]   wbReg;
    logic [REG_CNT-1:0] pending;

    modport master (
        output inValid, instruction, cFlag, zFlag, flush, outReady, wbValid, wbReg,
        input  inReady, outValid, nextPCSel, regDataInSource, immData, regFileWE,
               memWE, dAddrSel, regDst, regSrc1, regSrc2, aluOp, instrData, illegal, pending
    );

    modport slave (
        input  inValid, instruction, cFlag, zFlag, flush, outReady, wbValid, wbReg,
        output inReady, outValid, nextPCSel, regDataInSource, immData, regFileWE,
               memWE, dAddrSel, regDst, regSrc1, regSrc2, aluOp, instrData, illegal, pending
    );

endinterface

// File: rtl/decode_scoreboard.sv
// Pending-write scoreboard for in-flight memory loads, plus the read-hazard lookup
// that also covers a load still sitting in the decode output register.
module decode_scoreboard #(
    parameter int REG_CNT = 4,
    parameter int REG_W   = $clog2(REG_CNT)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               setEn,
    input  logic [REG_W-1:0]   setReg,
    input  logic               clrEn,
    input  logic [REG_W-1:0]   clrReg,
    input  logic               rdEn1,
    input  logic [REG_W-1:0]   rdReg1,
    input  logic               rdEn2,
    input  logic [REG_W-1:0]   rdReg2,
    input  logic               fwdValid,
    input  logic [REG_W-1:0]   fwdReg,
    output logic [REG_CNT-1:0] pending,
    output logic               hazard
);

    logic busy1;
    logic busy2;

    // Set beats clear so a load issued as an older one retires keeps its claim.
    for (genvar i = 0; i < REG_CNT; i++) begin : gBit
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n)
                pending[i] <= 1'b0;
            else if (setEn && setReg == REG_W'(i))
                pending[i] <= 1'b1;
            else if (clrEn && clrReg == REG_W'(i))
                pending[i] <= 1'b0;
        end
    end

    always_comb begin
        busy1  = pending[rdReg1] || (fwdValid && fwdReg == rdReg1);
        busy2  = pending[rdReg2] || (fwdValid && fwdReg == rdReg2);
        hazard = (rdEn1 && busy1) || (rdEn2 && busy2);
    end

endmodule

// File: rtl/decode_stage.sv
// Registered toycpu decode stage: decodes the offered instruction, stalls on
// load-use hazards and holds the control bundle until execute takes it.
module decode_stage
    import toycpu_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int REG_CNT = 4,
    parameter int ALUOP_W = 7
) (
    input logic           clk,
    input logic           reset_n,
    decode_stage_if.slave io
);

    localparam int REG_W = $clog2(REG_CNT);
    localparam int PL_W  = DATA_W - 3 - REG_W;

    function automatic ctrl_t decode(input logic [2:0] op, input logic taken);
        ctrl_t c;
        c = '0;
        case (op)
            OP_ALU: c.regFileWE = 1'b1;
            OP_LDI: begin
                c.immData   = 1'b1;
                c.regFileWE = 1'b1;
            end
            OP_LDR: begin
                c.dAddrSel        = 1'b1;
                c.regDataInSource = 1'b1;
                c.regFileWE       = 1'b1;
            end
            OP_ST: begin
                c.dAddrSel = 1'b1;
                c.memWE    = 1'b1;
            end
            OP_BR:   c.nextPCSel = taken ? PC_BR : PC_INC;
            default: c.illegal   = 1'b1;
        endcase
        return c;
    endfunction

    logic [2:0]         opIn;
    logic [REG_W-1:0]   dstIn;
    logic [REG_W-1:0]   src1In;
    logic [REG_W-1:0]   src2In;
    logic [PL_W-1:0]    payloadIn;
    logic               brTaken;
    ctrl_t              ctrlIn;
    logic [DATA_W-1:0]  immIn;
    logic               rdEn1;
    logic               rdEn2;

    ctrl_t              ctrlQ;
    logic               outValidQ;
    logic [REG_W-1:0]   dstQ;
    logic [REG_W-1:0]   src1Q;
    logic [REG_W-1:0]   src2Q;
    logic [ALUOP_W-1:0] aluOpQ;
    logic [DATA_W-1:0]  instrDataQ;

    logic               hazard;
    logic               accept;
    logic               outHs;

    assign opIn      = io.instruction[DATA_W-1 -: 3];
    assign dstIn     = io.instruction[DATA_W-4 -: REG_W];
    assign src1In    = io.instruction[DATA_W-4-REG_W -: REG_W];
    assign src2In    = io.instruction[DATA_W-4-2*REG_W -: REG_W];
    assign payloadIn = io.instruction[PL_W-1:0];
    assign brTaken   = (io.instruction[DATA_W-4] ? io.zFlag : io.cFlag) == io.instruction[DATA_W-5];

    always_comb begin
        ctrlIn = decode(opIn, brTaken);
        immIn  = '0;
        if (ctrlIn.immData)
            immIn = {{(DATA_W-PL_W){1'b0}}, payloadIn};
        else if (ctrlIn.nextPCSel == PC_BR)
            immIn = {{(DATA_W-PL_W){payloadIn[PL_W-1]}}, payloadIn};
        rdEn1 = (opIn == OP_ALU) || (opIn == OP_LDR) || (opIn == OP_ST);
        rdEn2 = (opIn == OP_ALU) || (opIn == OP_ST);
    end

    // Only an indirect load drives regDataInSource, so it marks a load in the entry.
    decode_scoreboard #(.REG_CNT(REG_CNT)) uScoreboard (
        .clk      (clk),
        .reset_n  (reset_n),
        .setEn    (outHs && ctrlQ.regDataInSource),
        .setReg   (dstQ),
        .clrEn    (io.wbValid),
        .clrReg   (io.wbReg),
        .rdEn1    (rdEn1),
        .rdReg1   (src1In),
        .rdEn2    (rdEn2),
        .rdReg2   (src2In),
        .fwdValid (outValidQ && ctrlQ.regDataInSource),
        .fwdReg   (dstQ),
        .pending  (io.pending),
        .hazard   (hazard)
    );

    assign io.inReady = !io.flush && !hazard && (!outValidQ || io.outReady);
    assign accept     = io.inValid && io.inReady;
    assign outHs      = outValidQ && io.outReady;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            outValidQ  <= 1'b0;
            ctrlQ      <= '0;
            dstQ       <= '0;
            src1Q      <= '0;
            src2Q      <= '0;
            aluOpQ     <= '0;
            instrDataQ <= '0;
        end else if (accept) begin
            outValidQ  <= 1'b1;
            ctrlQ      <= ctrlIn;
            dstQ       <= dstIn;
            src1Q      <= src1In;
            src2Q      <= src2In;
            aluOpQ     <= io.instruction[ALUOP_W-1:0];
            instrDataQ <= immIn;
        end else if (io.flush || outHs) begin
            outValidQ  <= 1'b0;
        end
    end

    assign io.outValid        = outValidQ;
    assign io.nextPCSel       = ctrlQ.nextPCSel;
    assign io.regDataInSource = ctrlQ.regDataInSource;
    assign io.immData         = ctrlQ.immData;
    assign io.regFileWE       = ctrlQ.regFileWE;
    assign io.memWE           = ctrlQ.memWE;
    assign io.dAddrSel        = ctrlQ.dAddrSel;
    assign io.illegal         = ctrlQ.illegal;
    assign io.regDst          = dstQ;
    assign io.regSrc1         = src1Q;
    assign io.regSrc2         = src2Q;
    assign io.aluOp           = aluOpQ;
    assign io.instrData       = instrDataQ;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: hand-computed expectations per scenario.
module tb_decode_stage;

    logic clk;
    logic reset_n;
    int   total;
    int   bad;

    decode_stage_if #(.DATA_W(16), .REG_CNT(4), .ALUOP_W(7)) bus ();

    decode_stage #(.DATA_W(16), .REG_CNT(4), .ALUOP_W(7)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .io      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        reset_n         = 1'b0;
        bus.inValid     = 1'b0;
        bus.instruction = '0;
        bus.cFlag       = 1'b0;
        bus.zFlag       = 1'b0;
        bus.flush       = 1'b0;
        bus.outReady    = 1'b1;
        bus.wbValid     = 1'b0;
        bus.wbReg       = '0;
        #12;
        total++; if (bus.outValid !== 1'b0) begin bad++; $display("FAIL reset_outValid got=%0b want=0", bus.outValid); end
        total++; if (bus.pending !== 4'b0000) begin bad++; $display("FAIL reset_pending got=%b want=0000", bus.pending); end
        total++; if (bus.illegal !== 1'b0) begin bad++; $display("FAIL reset_illegal got=%0b want=0", bus.illegal); end
        total++; if (bus.instrData !== 16'h0000) begin bad++; $display("FAIL reset_instrData got=%h want=0000", bus.instrData); end
        total++; if (bus.nextPCSel !== 2'b00) begin bad++; $display("FAIL reset_nextPCSel got=%b want=00", bus.nextPCSel); end
        reset_n = 1'b1;
    endtask

    task automatic test_ldi();
        bus.instruction = 16'h2923;
        bus.inValid     = 1'b1;
        tick();
        bus.inValid = 1'b0;
        total++; if (bus.outValid !== 1'b1) begin bad++; $display("FAIL ldi_outValid got=%0b want=1", bus.outValid); end
        total++; if (bus.regDst !== 2'd1) begin bad++; $display("FAIL ldi_regDst got=%0d want=1", bus.regDst); end
        total++; if (bus.immData !== 1'b1) begin bad++; $display("FAIL ldi_immData got=%0b want=1", bus.immData); end
        total++; if (bus.regFileWE !== 1'b1) begin bad++; $display("FAIL ldi_regFileWE got=%0b want=1", bus.regFileWE); end
        total++; if (bus.instrData !== 16'h0123) begin bad++; $display("FAIL ldi_instrData got=%h want=0123", bus.instrData); end
        total++; if (bus.illegal !== 1'b0) begin bad++; $display("FAIL ldi_illegal got=%0b want=0", bus.illegal); end
        tick();
        total++; if (bus.outValid !== 1'b0) begin bad++; $display("FAIL ldi_drain got=%0b want=0", bus.outValid); end
    endtask

    task automatic test_load_use();
        bus.instruction = 16'h7200;
        bus.inValid     = 1'b1;
        #1;
        total++; if (bus.inReady !== 1'b1) begin bad++; $display("FAIL ldr_inReady got=%0b want=1", bus.inReady); end
        tick();
        bus.instruction = 16'h1C01;
        #1;
        total++; if (bus.inReady !== 1'b0) begin bad++; $display("FAIL use_entry_stall got=%0b want=0", bus.inReady); end
        total++; if (bus.dAddrSel !== 1'b1 || bus.regDataInSource !== 1'b1) begin bad++; $display("FAIL ldr_strobes got=%0b%0b want=11", bus.dAddrSel, bus.regDataInSource); end
        tick();
        total++; if (bus.pending !== 4'b0100) begin bad++; $display("FAIL use_pending got=%b want=0100", bus.pending); end
        total++; if (bus.inReady !== 1'b0) begin bad++; $display("FAIL use_pending_stall got=%0b want=0", bus.inReady); end
        total++; if (bus.outValid !== 1'b0) begin bad++; $display("FAIL use_no_accept got=%0b want=0", bus.outValid); end
        bus.wbValid = 1'b1;
        bus.wbReg   = 2'd2;
        tick();
        bus.wbValid = 1'b0;
        #1;
        total++; if (bus.pending !== 4'b0000) begin bad++; $display("FAIL wb_clear got=%b want=0000", bus.pending); end
        total++; if (bus.outValid !== 1'b0) begin bad++; $display("FAIL wb_no_bypass got=%0b want=0", bus.outValid); end
        total++; if (bus.inReady !== 1'b1) begin bad++; $display("FAIL wb_release got=%0b want=1", bus.inReady); end
        tick();
        bus.inValid = 1'b0;
        total++; if (bus.outValid !== 1'b1) begin bad++; $display("FAIL alu_outValid got=%0b want=1", bus.outValid); end
        total++; if (bus.regDst !== 2'd3 || bus.regSrc1 !== 2'd2 || bus.regSrc2 !== 2'd0) begin bad++; $display("FAIL alu_regs got=%0d,%0d,%0d want=3,2,0", bus.regDst, bus.regSrc1, bus.regSrc2); end
        total++; if (bus.aluOp !== 7'h01) begin bad++; $display("FAIL alu_aluOp got=%h want=01", bus.aluOp); end
        total++; if (bus.regFileWE !== 1'b1 || bus.memWE !== 1'b0) begin bad++; $display("FAIL alu_strobes got=%0b%0b want=10", bus.regFileWE, bus.memWE); end
        tick();
    endtask

    task automatic test_branch();
        bus.outReady    = 1'b0;
        bus.instruction = 16'hDFFF;
        bus.zFlag       = 1'b1;
        bus.cFlag       = 1'b0;
        bus.inValid     = 1'b1;
        tick();
        bus.inValid = 1'b0;
        bus.zFlag   = 1'b0;
        tick();
        total++; if (bus.nextPCSel !== 2'b01) begin bad++; $display("FAIL br_taken_sel got=%b want=01", bus.nextPCSel); end
        total++; if (bus.instrData !== 16'hFFFF) begin bad++; $display("FAIL br_taken_off got=%h want=ffff", bus.instrData); end
        bus.outReady = 1'b1;
        bus.inValid  = 1'b1;
        #1;
        total++; if (bus.inReady !== 1'b1) begin bad++; $display("FAIL br_replace_ready got=%0b want=1", bus.inReady); end
        tick();
        bus.inValid = 1'b0;
        total++; if (bus.outValid !== 1'b1) begin bad++; $display("FAIL br_replace_valid got=%0b want=1", bus.outValid); end
        total++; if (bus.nextPCSel !== 2'b00) begin bad++; $display("FAIL br_not_taken_sel got=%b want=00", bus.nextPCSel); end
        total++; if (bus.instrData !== 16'h0000) begin bad++; $display("FAIL br_not_taken_off got=%h want=0000", bus.instrData); end
        tick();
    endtask

    task automatic test_illegal();
        bus.instruction = 16'hE000;
        bus.inValid     = 1'b1;
        tick();
        bus.inValid = 1'b0;
        total++; if (bus.illegal !== 1'b1) begin bad++; $display("FAIL ill_flag got=%0b want=1", bus.illegal); end
        total++; if (bus.regFileWE !== 1'b0 || bus.memWE !== 1'b0) begin bad++; $display("FAIL ill_strobes got=%0b%0b want=00", bus.regFileWE, bus.memWE); end
        total++; if (bus.nextPCSel !== 2'b00) begin bad++; $display("FAIL ill_nextPCSel got=%b want=00", bus.nextPCSel); end
        tick();
    endtask

    task automatic test_set_wins();
        bus.instruction = 16'h7200;
        bus.inValid     = 1'b1;
        tick();
        bus.inValid = 1'b0;
        bus.wbValid = 1'b1;
        bus.wbReg   = 2'd2;
        tick();
        bus.wbValid = 1'b0;
        total++; if (bus.pending !== 4'b0100) begin bad++; $display("FAIL set_wins got=%b want=0100", bus.pending); end
        bus.wbValid = 1'b1;
        bus.wbReg   = 2'd3;
        tick();
        bus.wbValid = 1'b0;
        total++; if (bus.pending !== 4'b0100) begin bad++; $display("FAIL clear_idle_reg got=%b want=0100", bus.pending); end
    endtask

    task automatic test_flush();
        bus.outReady    = 1'b0;
        bus.instruction = 16'h2923;
        bus.inValid     = 1'b1;
        tick();
        total++; if (bus.outValid !== 1'b1) begin bad++; $display("FAIL flush_pre_valid got=%0b want=1", bus.outValid); end
        bus.flush = 1'b1;
        #1;
        total++; if (bus.inReady !== 1'b0) begin bad++; $display("FAIL flush_block got=%0b want=0", bus.inReady); end
        tick();
        bus.flush   = 1'b0;
        bus.inValid = 1'b0;
        total++; if (bus.outValid !== 1'b0) begin bad++; $display("FAIL flush_drop got=%0b want=0", bus.outValid); end
        total++; if (bus.pending !== 4'b0100) begin bad++; $display("FAIL flush_pending got=%b want=0100", bus.pending); end
        bus.outReady = 1'b1;
    endtask

    task automatic test_reset_mid_stall();
        bus.instruction = 16'h1C01;
        bus.inValid     = 1'b1;
        #1;
        total++; if (bus.inReady !== 1'b0) begin bad++; $display("FAIL stall_before_reset got=%0b want=0", bus.inReady); end
        reset_n = 1'b0;
        #1;
        total++; if (bus.pending !== 4'b0000) begin bad++; $display("FAIL reset_clears_pending got=%b want=0000", bus.pending); end
        total++; if (bus.inReady !== 1'b1) begin bad++; $display("FAIL reset_releases_stall got=%0b want=1", bus.inReady); end
        reset_n = 1'b1;
        tick();
        bus.inValid = 1'b0;
        total++; if (bus.outValid !== 1'b1 || bus.regDst !== 2'd3) begin bad++; $display("FAIL post_reset_accept got=%0b/%0d want=1/3", bus.outValid, bus.regDst); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_ldi();
        test_load_use();
        test_branch();
        test_illegal();
        test_set_wins();
        test_flush();
        test_reset_mid_stall();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
